blink_ctrl: RTL and testbench
=============================

# blink_ctrl

Configurable blink controller that owns the LED prescaler counter and sequences the LED through off, solid, continuous-blink and counted-burst modes. It sits between a register or host interface (valid/ready configuration port) and the LED pin. It replaces free-running blink counters with one programmable prescaler plus a mode FSM. Its `tick`/`led` relationship is the invariant the formal properties check.

## Interface
- `CBITS`, default 8: prescaler width; the tick period is `cfg_period`+1 cycles.
- `NB`, default 4: burst-count width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration can be accepted.
- `cfg_mode` in 2: 0=IDLE, 1=SOLID, 2=BLINK, 3=BURST.
- `cfg_period` in CBITS: prescaler reload value.
- `cfg_count` in NB: number of burst pulses (on/off pairs).
- `led` out 1: LED drive, registered.
- `tick` out 1: registered one-cycle pulse on each prescaler expiry.
- `busy` out 1: high while in BURST.
- `done` out 1: registered one-cycle pulse when a burst completes.

## Operation
- FSM states are IDLE, SOLID, BLINK and BURST. Internal registers: `cnt[CBITS]`, `period[CBITS]`, `remain[NB]`.
- Reset values: state=IDLE, cnt=0, period=0, remain=0, led=0, tick=0, done=0.
- `cfg_ready` = (state != BURST), combinational. `busy` = (state == BURST).
- Accept occurs on an edge where `cfg_valid && cfg_ready`. On accept:
  - period ← cfg_period, cnt ← cfg_period, remain ← cfg_count.
  - state ← cfg_mode, and led ← (cfg_mode == SOLID). tick ← 0.
  - BURST with cfg_count=0 goes to IDLE instead, and done ← 1 on that edge.
- Active states are SOLID, BLINK and BURST. On an edge in an active state with no accept:
  - If cnt==0: cnt ← period, tick ← 1.
  - Otherwise: cnt ← cnt−1, tick ← 0.
- IDLE: cnt held at 0, tick ← 0, led ← 0.
- SOLID: led stays 1; ticks still generated.
- BLINK: led toggles on every tick edge, indefinitely.
- BURST: led toggles on every tick edge. On a tick edge where led==1 (falling toggle):
  - remain ← remain−1.
  - If remain==1, state ← IDLE and done ← 1 (led ← 0 on the same edge).
- `done` is 0 on every edge other than those listed above.
- Accept has priority over tick: on an accept edge there is no tick, no toggle and no decrement.
- Invariant: `led` changes value only on an edge that also sets `tick`=1, or on an accept edge, or on reset.
- Invariant: `done` implies state becomes IDLE and `led`=0.
- Arithmetic is unsigned modulo 2^CBITS and 2^NB. `remain` never underflows, because exit happens at 1.
- Reset mid-burst: immediate return to the reset values. No done pulse; a pending accept is lost.

## Timing
- Accept at edge T: the first tick is visible after edge T+cfg_period+1. Thereafter a tick occurs every cfg_period+1 cycles.
- cfg_period=0: tick every cycle; BLINK toggles led every cycle.
- A BURST of N pulses completes at edge T+2N·(cfg_period+1). The last tick, the led fall and done all share that edge.
- `cfg_ready` drops in the cycle after a BURST accept and rises in the cycle after done.
- Latency from accept to led update is 1 edge (led reflects the new mode immediately).
- Reconfiguration during SOLID/BLINK restarts the prescaler with no extra tick.

## Test plan
- Reset, then BLINK with period=3, accept at edge 0 → tick at edges 4, 8, 12…; led=1 after edge 4, 0 after 8, 1 after 12.
- BURST with period=1, count=3 → led high after edges 2, 6, 10 and low after 4, 8, 12. done pulses at edge 12 only; busy=1 from edge 0 to 12; cfg_ready=0 over the same span.
- During that burst, hold cfg_valid=1 with mode=SOLID → not accepted until the cycle after done. Then led=1 after the next edge.
- BLINK with period=0 → led alternates every cycle and tick is constantly 1. Then reconfigure to IDLE → led=0 and tick=0 after one edge.
- BURST with count=0 → state goes to IDLE, done=1 one cycle after accept, and led never rises.
- Assert rst asynchronously mid-burst (after edge 5 of the period=1, count=3 case) → led, tick, done and busy go to 0 immediately, cfg_ready=1, and there is no done pulse.

Source files
------------

// File: rtl/blink_ctrl.sv
// LED blink controller: a programmable prescaler plus a mode FSM.
// Modes are off, solid, continuous blink and a counted burst that pulses done when it finishes.
module blink_ctrl #(
    parameter int CBITS = 8,
    parameter int NB    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [CBITS-1:0] cfg_period,
    input  logic [NB-1:0]    cfg_count,
    output logic             led,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SOLID = 2'd1,
        S_BLINK = 2'd2,
        S_BURST = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] period_q, period_d;
    logic [NB-1:0]    remain_q, remain_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             accept;

    assign cfg_ready = (state_q != S_BURST);
    assign busy      = (state_q == S_BURST);
    assign accept    = cfg_valid && cfg_ready;
    assign led       = led_q;
    assign tick      = tick_q;
    assign done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            remain_q <= '0;
            led_q    <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            remain_q <= remain_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    // Accept takes priority over the prescaler: no tick, toggle or decrement on an accept edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        remain_d = remain_q;
        led_d    = led_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (accept) begin
            period_d = cfg_period;
            cnt_d    = cfg_period;
            remain_d = cfg_count;
            state_d  = state_e'(cfg_mode);
            led_d    = (cfg_mode == S_SOLID);
            if ((cfg_mode == S_BURST) && (cfg_count == '0)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
            led_d = 1'b0;
        end else begin
            if (cnt_q == '0) begin
                cnt_d  = period_q;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end

            case (state_q)
                S_SOLID: led_d = 1'b1;
                S_BLINK: begin
                    if (cnt_q == '0) led_d = ~led_q;
                end
                S_BURST: begin
                    if (cnt_q == '0) begin
                        led_d = ~led_q;
                        // A falling toggle closes one on/off pair; exit at 1 so remain never wraps.
                        if (led_q) begin
                            remain_d = remain_q - 1'b1;
                            if (remain_q == {{(NB-1){1'b0}}, 1'b1}) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                led_d   = 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl: blink, burst, held request, period 0, empty burst, async reset.
module tb_blink_ctrl;

    localparam int CBITS = 8;
    localparam int NB    = 4;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [CBITS-1:0] cfg_period;
    logic [NB-1:0]    cfg_count;
    logic             led;
    logic             tick;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    blink_ctrl #(.CBITS(CBITS), .NB(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .led        (led),
        .tick       (tick),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] m, input int p, input int c);
        cfg_valid  = 1'b1;
        cfg_mode   = m;
        cfg_period = CBITS'(p);
        cfg_count  = NB'(c);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_mode   = 2'd0;
        cfg_period = '0;
        cfg_count  = '0;
        step();
        step();
        chk("rst_led",   led,       1'b0);
        chk("rst_tick",  tick,      1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        rst = 1'b0;
        step();

        // BLINK, period 3: tick at edges 4, 8, 12; led toggles on each.
        offer(2'd2, 3, 0);
        step();
        cfg_valid = 1'b0;
        chk("blink_acc_led",  led,  1'b0);
        chk("blink_acc_tick", tick, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("blink_tick_e%0d", e), tick, (e % 4 == 0));
            chk($sformatf("blink_led_e%0d", e),  led,  ((e / 4) % 2 == 1));
        end

        // BURST period 1 count 3, with a SOLID request held throughout.
        offer(2'd3, 1, 3);
        step();
        chk("burst_acc_led",   led,       1'b0);
        chk("burst_acc_busy",  busy,      1'b1);
        chk("burst_acc_ready", cfg_ready, 1'b0);
        offer(2'd1, 2, 0);
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("burst_led_e%0d", e),   led,
                (e == 2 || e == 3 || e == 6 || e == 7 || e == 10 || e == 11));
            chk($sformatf("burst_done_e%0d", e),  done,      (e == 12));
            chk($sformatf("burst_busy_e%0d", e),  busy,      (e < 12));
            chk($sformatf("burst_ready_e%0d", e), cfg_ready, (e >= 12));
        end
        step();
        cfg_valid = 1'b0;
        chk("held_solid_led",  led,  1'b1);
        chk("held_solid_done", done, 1'b0);
        chk("held_solid_busy", busy, 1'b0);
        for (int e = 14; e <= 16; e++) begin
            step();
            chk($sformatf("solid_tick_e%0d", e), tick, (e == 16));
            chk($sformatf("solid_led_e%0d", e),  led,  1'b1);
        end

        // BLINK period 0: tick every cycle, led alternates; then back to IDLE.
        offer(2'd2, 0, 0);
        step();
        cfg_valid = 1'b0;
        chk("p0_acc_led", led, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("p0_tick_e%0d", e), tick, 1'b1);
            chk($sformatf("p0_led_e%0d", e),  led,  (e % 2 == 1));
        end
        offer(2'd0, 0, 0);
        step();
        cfg_valid = 1'b0;
        chk("idle_led",  led,  1'b0);
        chk("idle_tick", tick, 1'b0);

        // BURST with count 0: immediate done, led never rises.
        offer(2'd3, 2, 0);
        step();
        cfg_valid = 1'b0;
        chk("empty_done",  done,      1'b1);
        chk("empty_led",   led,       1'b0);
        chk("empty_busy",  busy,      1'b0);
        chk("empty_ready", cfg_ready, 1'b1);
        for (int e = 2; e <= 5; e++) begin
            step();
            chk($sformatf("empty_done_e%0d", e), done, 1'b0);
            chk($sformatf("empty_led_e%0d", e),  led,  1'b0);
        end

        // Async reset after edge 5 of a period 1, count 3 burst.
        offer(2'd3, 1, 3);
        step();
        cfg_valid = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_led",   led,       1'b0);
        chk("arst_tick",  tick,      1'b0);
        chk("arst_done",  done,      1'b0);
        chk("arst_busy",  busy,      1'b0);
        chk("arst_ready", cfg_ready, 1'b1);
        step();
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            chk($sformatf("post_rst_done_%0d", e), done, 1'b0);
            chk($sformatf("post_rst_led_%0d", e),  led,  1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
